// File: rtl/target_io_pkg.sv
// Shared definitions for the target I/O controller: channel modes, PWR control
// bit positions and the power-sequencer state type.
package target_io_pkg;

    typedef enum logic [1:0] {
        IOMODE_HIZ  = 2'd0,
        IOMODE_GPIO = 2'd1,
        IOMODE_ALT  = 2'd2,
        IOMODE_OD   = 2'd3
    } iomode_e;

    localparam int PWR_BIT_EN    = 0;
    localparam int PWR_BIT_PULSE = 1;
    localparam int PWR_BIT_CLR   = 2;
    localparam int PWR_LEN       = 5;

    typedef enum logic [1:0] {
        PWR_OFF    = 2'd0,
        PWR_SETTLE = 2'd1,
        PWR_ON     = 2'd2
    } pwr_state_e;

    function automatic int gpio_bytes(input int num_io);
        return (num_io + 7) / 8;
    endfunction

endpackage

// File: rtl/target_pwr_seq.sv
// Target power sequencer: OFF/SETTLE/ON state machine with settle timer,
// self-timed nRST pulse counter and sticky dropped-pulse flag.
module target_pwr_seq
    import target_io_pkg::*;
#(
    parameter int pDLY_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  power_en,
    input  logic                  pulse_req,
    input  logic                  clear_dropped,
    input  logic [pDLY_WIDTH-1:0] settle,
    input  logic [pDLY_WIDTH-1:0] pulse_len,
    output logic                  force_hiz,
    output logic                  power_good,
    output logic                  target_npower,
    output logic                  nrst_oe,
    output logic                  pulse_dropped
);

    localparam logic [pDLY_WIDTH-1:0] CNT_ONE = pDLY_WIDTH'(1);

    pwr_state_e            state_q, state_d;
    logic [pDLY_WIDTH-1:0] settle_cnt_q, settle_cnt_d;
    logic [pDLY_WIDTH-1:0] pulse_cnt_q, pulse_cnt_d;
    logic                  dropped_q, dropped_d;
    logic                  req_ok;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        pulse_cnt_d  = (pulse_cnt_q != '0) ? pulse_cnt_q - CNT_ONE : '0;
        dropped_d    = dropped_q;
        req_ok       = power_en && (state_q == PWR_ON);

        if (!power_en) begin
            state_d      = PWR_OFF;
            settle_cnt_d = '0;
            pulse_cnt_d  = '0;
        end else begin
            case (state_q)
                PWR_OFF: begin
                    state_d      = PWR_SETTLE;
                    settle_cnt_d = settle;
                end
                PWR_SETTLE: begin
                    // A settle count of 0 or 1 both give a single settle cycle.
                    if (settle_cnt_q <= CNT_ONE) state_d = PWR_ON;
                    else settle_cnt_d = settle_cnt_q - CNT_ONE;
                end
                PWR_ON: ;
                default: state_d = PWR_OFF;
            endcase
        end

        if (pulse_req && req_ok)
            pulse_cnt_d = (pulse_len == '0) ? CNT_ONE : pulse_len;

        if (clear_dropped) dropped_d = 1'b0;
        if (pulse_req && !req_ok) dropped_d = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= PWR_OFF;
            settle_cnt_q <= '0;
            pulse_cnt_q  <= '0;
            dropped_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            pulse_cnt_q  <= pulse_cnt_d;
            dropped_q    <= dropped_d;
        end
    end

    // Pad enables are registered from the next state so hi-Z tracks state changes exactly.
    assign force_hiz     = (state_d != PWR_ON);
    assign power_good    = (state_q == PWR_ON);
    assign target_npower = (state_q == PWR_OFF);
    assign nrst_oe       = (pulse_cnt_q != '0);
    assign pulse_dropped = dropped_q;

endmodule

// File: rtl/target_io_ctrl.sv
// Target I/O controller: register bank, per-channel mode mux, input synchroniser
// and pad tri-states, with power sequencing delegated to target_pwr_seq.
module target_io_ctrl
    import target_io_pkg::*;
#(
    parameter int         pNUM_IO      = 8,
    parameter logic [5:0] pADDR_IOMODE = 6'd56,
    parameter logic [5:0] pADDR_GPIO   = 6'd57,
    parameter logic [5:0] pADDR_PWR    = 6'd58,
    parameter int         pDLY_WIDTH   = 16
) (
    input  logic               clk,
    input  logic               reset_i,
    input  logic [5:0]         reg_address,
    input  logic [15:0]        reg_bytecnt,
    input  logic [7:0]         reg_datai,
    output logic [7:0]         reg_datao,
    input  logic               reg_read,
    input  logic               reg_write,
    input  logic               reg_addrvalid,
    input  logic [5:0]         reg_hypaddress,
    output logic [15:0]        reg_hyplen,
    input  logic [pNUM_IO-1:0] io_i,
    output logic [pNUM_IO-1:0] io_o,
    output logic [pNUM_IO-1:0] io_oe,
    input  logic [pNUM_IO-1:0] alt_out_i,
    input  logic [pNUM_IO-1:0] alt_oe_i,
    output logic [pNUM_IO-1:0] alt_in_o,
    output logic               target_npower,
    output logic               nrst_o,
    output logic               nrst_oe,
    output logic [1:0]         status_o
);

    localparam int GPIO_BYTES = gpio_bytes(pNUM_IO);

    logic [7:0]              iomode [pNUM_IO];
    logic [pNUM_IO-1:0]      gpio_out;
    logic [pNUM_IO-1:0]      sync_meta, sync_q;
    logic [GPIO_BYTES*8-1:0] sync_pad;
    logic                    power_en;
    logic [15:0]             settle_reg, pulse_len_reg;
    logic [7:0]              read_byte;
    logic [pNUM_IO-1:0]      io_o_d, io_oe_d;

    logic wr_en, pwr_byte0_wr, power_en_eff, pulse_req, clear_dropped;
    logic force_hiz, power_good, pulse_dropped;

    assign wr_en        = reg_write & reg_addrvalid;
    assign pwr_byte0_wr = wr_en && (reg_address == pADDR_PWR) && (reg_bytecnt == 16'd0);
    // The sequencer sees a byte0 write in the same cycle, so its bits act together.
    assign power_en_eff  = pwr_byte0_wr ? reg_datai[PWR_BIT_EN] : power_en;
    assign pulse_req     = pwr_byte0_wr & reg_datai[PWR_BIT_PULSE];
    assign clear_dropped = pwr_byte0_wr & reg_datai[PWR_BIT_CLR];

    // NOTE: the mode array is reset explicitly because its value drives the pads after power-up.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            for (int ch = 0; ch < pNUM_IO; ch++) iomode[ch] <= 8'h00;
            gpio_out      <= '0;
            power_en      <= 1'b0;
            settle_reg    <= '0;
            pulse_len_reg <= '0;
        end else if (wr_en) begin
            if (reg_address == pADDR_IOMODE) begin
                for (int ch = 0; ch < pNUM_IO; ch++)
                    if (reg_bytecnt == 16'(ch)) iomode[ch] <= reg_datai;
            end else if (reg_address == pADDR_GPIO) begin
                for (int i = 0; i < pNUM_IO; i++)
                    if (reg_bytecnt == 16'(i / 8)) gpio_out[i] <= reg_datai[i % 8];
            end else if (reg_address == pADDR_PWR) begin
                case (reg_bytecnt)
                    16'd0:   power_en             <= reg_datai[PWR_BIT_EN];
                    16'd1:   settle_reg[7:0]      <= reg_datai;
                    16'd2:   settle_reg[15:8]     <= reg_datai;
                    16'd3:   pulse_len_reg[7:0]   <= reg_datai;
                    16'd4:   pulse_len_reg[15:8]  <= reg_datai;
                    default: ;
                endcase
            end
        end
    end

    assign sync_pad = (GPIO_BYTES*8)'(sync_q);

    always_comb begin
        read_byte = 8'h00;
        if (reg_address == pADDR_IOMODE) begin
            for (int ch = 0; ch < pNUM_IO; ch++)
                if (reg_bytecnt == 16'(ch)) read_byte = iomode[ch];
        end else if (reg_address == pADDR_GPIO) begin
            for (int b = 0; b < GPIO_BYTES; b++)
                if (reg_bytecnt == 16'(b)) read_byte = sync_pad[b*8 +: 8];
        end else if (reg_address == pADDR_PWR) begin
            case (reg_bytecnt)
                16'd0:   read_byte = {7'b0, power_en};
                16'd1:   read_byte = settle_reg[7:0];
                16'd2:   read_byte = settle_reg[15:8];
                16'd3:   read_byte = pulse_len_reg[7:0];
                16'd4:   read_byte = pulse_len_reg[15:8];
                default: read_byte = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) reg_datao <= 8'h00;
        else         reg_datao <= (reg_read & reg_addrvalid) ? read_byte : 8'h00;
    end

    always_comb begin
        reg_hyplen = 16'd0;
        if      (reg_hypaddress == pADDR_IOMODE) reg_hyplen = 16'(pNUM_IO);
        else if (reg_hypaddress == pADDR_GPIO)   reg_hyplen = 16'(GPIO_BYTES);
        else if (reg_hypaddress == pADDR_PWR)    reg_hyplen = 16'(PWR_LEN);
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= io_i;
            sync_q    <= sync_meta;
        end
    end

    assign alt_in_o = sync_q;

    always_comb begin
        io_o_d  = '0;
        io_oe_d = '0;
        for (int ch = 0; ch < pNUM_IO; ch++) begin
            case (iomode_e'(iomode[ch][1:0]))
                IOMODE_GPIO: begin
                    io_o_d[ch]  = gpio_out[ch];
                    io_oe_d[ch] = 1'b1;
                end
                IOMODE_ALT: begin
                    io_o_d[ch]  = alt_out_i[ch];
                    io_oe_d[ch] = alt_oe_i[ch];
                end
                IOMODE_OD: begin
                    io_o_d[ch]  = 1'b0;
                    io_oe_d[ch] = ~alt_out_i[ch];
                end
                default: begin
                    io_o_d[ch]  = 1'b0;
                    io_oe_d[ch] = 1'b0;
                end
            endcase
        end
        if (force_hiz) io_oe_d = '0;
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            io_o  <= '0;
            io_oe <= '0;
        end else begin
            io_o  <= io_o_d;
            io_oe <= io_oe_d;
        end
    end

    target_pwr_seq #(
        .pDLY_WIDTH(pDLY_WIDTH)
    ) u_pwr_seq (
        .clk           (clk),
        .rst           (reset_i),
        .power_en      (power_en_eff),
        .pulse_req     (pulse_req),
        .clear_dropped (clear_dropped),
        .settle        (pDLY_WIDTH'(settle_reg)),
        .pulse_len     (pDLY_WIDTH'(pulse_len_reg)),
        .force_hiz     (force_hiz),
        .power_good    (power_good),
        .target_npower (target_npower),
        .nrst_oe       (nrst_oe),
        .pulse_dropped (pulse_dropped)
    );

    assign nrst_o   = 1'b0;
    assign status_o = {pulse_dropped, power_good};

endmodule

// File: tb/tb_target_io_ctrl.sv
// Self-checking bench for target_io_ctrl: directed power/pulse scenarios plus
// randomized mode, pad and pulse traffic against a timestamp-based reference model.
module tb_target_io_ctrl;

    localparam int         N      = 8;
    localparam logic [5:0] A_IOM  = 6'd56;
    localparam logic [5:0] A_GPIO = 6'd57;
    localparam logic [5:0] A_PWR  = 6'd58;

    logic         clk = 1'b0;
    logic         reset_i;
    logic [5:0]   reg_address;
    logic [15:0]  reg_bytecnt;
    logic [7:0]   reg_datai;
    logic [7:0]   reg_datao;
    logic         reg_read, reg_write, reg_addrvalid;
    logic [5:0]   reg_hypaddress;
    logic [15:0]  reg_hyplen;
    logic [N-1:0] io_i, io_o, io_oe, alt_out_i, alt_oe_i, alt_in_o;
    logic         target_npower, nrst_o, nrst_oe;
    logic [1:0]   status_o;

    always #5 clk = ~clk;

    target_io_ctrl #(
        .pNUM_IO(N), .pADDR_IOMODE(A_IOM), .pADDR_GPIO(A_GPIO),
        .pADDR_PWR(A_PWR), .pDLY_WIDTH(16)
    ) dut (
        .clk(clk), .reset_i(reset_i),
        .reg_address(reg_address), .reg_bytecnt(reg_bytecnt),
        .reg_datai(reg_datai), .reg_datao(reg_datao),
        .reg_read(reg_read), .reg_write(reg_write), .reg_addrvalid(reg_addrvalid),
        .reg_hypaddress(reg_hypaddress), .reg_hyplen(reg_hyplen),
        .io_i(io_i), .io_o(io_o), .io_oe(io_oe),
        .alt_out_i(alt_out_i), .alt_oe_i(alt_oe_i), .alt_in_o(alt_in_o),
        .target_npower(target_npower), .nrst_o(nrst_o), .nrst_oe(nrst_oe),
        .status_o(status_o)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: power-on time, pulse end time and sticky flag as timestamps.
    logic [7:0] m_mode [N];
    logic [7:0] m_gpio;
    bit         m_powered, m_dropped;
    int         m_on_at, m_pulse_end, m_settle, m_plen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int at_least_one(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < N; ch++) m_mode[ch] = 8'h00;
        m_gpio = 8'h00; m_powered = 0; m_dropped = 0;
        m_on_at = 0; m_pulse_end = 0; m_settle = 0; m_plen = 0;
    endtask

    task automatic wr(input logic [5:0] a, input int idx, input logic [7:0] d);
        reg_address = a; reg_bytecnt = 16'(idx); reg_datai = d;
        reg_write = 1'b1; reg_addrvalid = 1'b1;
        tick();
        reg_write = 1'b0; reg_addrvalid = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, input int idx, output logic [7:0] d);
        reg_address = a; reg_bytecnt = 16'(idx);
        reg_read = 1'b1; reg_addrvalid = 1'b1;
        tick();
        d = reg_datao;
        reg_read = 1'b0; reg_addrvalid = 1'b0;
    endtask

    task automatic set_mode(input int ch, input logic [7:0] v);
        m_mode[ch] = v;
        wr(A_IOM, ch, v);
    endtask

    task automatic set_settle(input int v);
        m_settle = v;
        wr(A_PWR, 1, 8'(v)); wr(A_PWR, 2, 8'(v >> 8));
    endtask

    task automatic set_plen(input int v);
        m_plen = v;
        wr(A_PWR, 3, 8'(v)); wr(A_PWR, 4, 8'(v >> 8));
    endtask

    // Byte0 write; the model applies the power rules at the edge the write lands on.
    task automatic pwr_write(input logic [7:0] b0);
        bit in_on;
        wr(A_PWR, 0, b0);
        in_on = m_powered && ((cyc - 1) >= m_on_at);
        if (!b0[0]) begin
            m_powered = 0; m_pulse_end = 0;
        end else if (!m_powered) begin
            m_powered = 1; m_on_at = cyc + at_least_one(m_settle);
        end
        if (b0[2]) m_dropped = 0;
        if (b0[1]) begin
            if (b0[0] && in_on) m_pulse_end = cyc + at_least_one(m_plen);
            else                m_dropped   = 1;
        end
    endtask

    task automatic chk_ctrl(input string tag);
        bit on;
        on = m_powered && (cyc >= m_on_at);
        check({tag, ".npower"}, 32'(target_npower), 32'(!m_powered));
        check({tag, ".nrst_oe"}, 32'(nrst_oe), 32'(cyc < m_pulse_end));
        check({tag, ".nrst_o"}, 32'(nrst_o), 32'd0);
        check({tag, ".status"}, 32'(status_o), {30'd0, m_dropped, on});
    endtask

    task automatic chk_io(input string tag);
        logic [N-1:0] eo, eoe;
        bit on;
        on = m_powered && (cyc >= m_on_at);
        eo = '0; eoe = '0;
        for (int ch = 0; ch < N; ch++) begin
            case (m_mode[ch] % 4)
                1: begin eo[ch] = m_gpio[ch];    eoe[ch] = 1'b1; end
                2: begin eo[ch] = alt_out_i[ch]; eoe[ch] = alt_oe_i[ch]; end
                3: begin eo[ch] = 1'b0;          eoe[ch] = ~alt_out_i[ch]; end
                default: ;
            endcase
        end
        if (!on) eoe = '0;
        check({tag, ".io_oe"}, 32'(io_oe), 32'(eoe));
        check({tag, ".io_o"}, 32'(io_o & eoe), 32'(eo & eoe));
    endtask

    initial begin
        logic [7:0] d;
        logic [N-1:0] v, prev;

        reset_i = 1'b1; reg_address = '0; reg_bytecnt = '0; reg_datai = '0;
        reg_read = 0; reg_write = 0; reg_addrvalid = 0; reg_hypaddress = '0;
        io_i = '0; alt_out_i = '0; alt_oe_i = '0;
        model_reset();
        repeat (3) tick();
        check("rst.io_oe", 32'(io_oe), 32'h0);
        check("rst.io_o", 32'(io_o), 32'h0);
        check("rst.datao", 32'(reg_datao), 32'h0);
        chk_ctrl("rst");
        reset_i = 1'b0;
        tick();

        reg_hypaddress = A_IOM;  #1 check("hyplen.iomode", 32'(reg_hyplen), 32'd8);
        reg_hypaddress = A_GPIO; #1 check("hyplen.gpio", 32'(reg_hyplen), 32'd1);
        reg_hypaddress = A_PWR;  #1 check("hyplen.pwr", 32'(reg_hyplen), 32'd5);
        reg_hypaddress = 6'd3;   #1 check("hyplen.other", 32'(reg_hyplen), 32'd0);
        for (int b = 0; b < 5; b++) begin
            rd(A_PWR, b, d);
            check($sformatf("rst.pwr_byte%0d", b), 32'(d), 32'h0);
        end
        tick();
        check("datao.idle", 32'(reg_datao), 32'h0);

        // Power-on with ch0 GPIO high and a 10-cycle settle.
        set_mode(0, 8'h01);
        m_gpio = 8'h01; wr(A_GPIO, 0, 8'h01);
        set_settle(10);
        rd(A_IOM, 0, d);
        check("iomode0.read", 32'(d), 32'h01);
        pwr_write(8'h01);
        chk_ctrl("pwron");
        chk_io("pwron");
        for (int k = 0; k < 12; k++) begin
            tick();
            chk_ctrl("settle");
            chk_io("settle");
        end
        check("pwron.io_oe0", 32'(io_oe[0]), 32'd1);

        // Directed ALT on ch3, open-drain on ch4.
        set_mode(3, 8'h02);
        set_mode(4, 8'h03);
        alt_oe_i = 8'h08; alt_out_i = 8'h08;
        tick();
        check("alt.io_o3", 32'(io_o[3]), 32'd1);
        check("alt.oe43", 32'(io_oe[4:3]), 32'h3);
        chk_io("alt");

        // Randomized modes, GPIO data and alternate-function traffic.
        for (int it = 0; it < 6; it++) begin
            for (int ch = 0; ch < N; ch++) set_mode(ch, 8'($urandom));
            m_gpio = 8'($urandom); wr(A_GPIO, 0, m_gpio);
            for (int k = 0; k < 4; k++) begin
                alt_out_i = N'($urandom); alt_oe_i = N'($urandom);
                tick();
                chk_io($sformatf("rand%0d", it));
            end
        end
        rd(A_IOM, 5, d);
        check("iomode5.read", 32'(d), 32'(m_mode[5]));

        // Input synchroniser and GPIO readback of pad state.
        prev = alt_in_o;
        for (int it = 0; it < 5; it++) begin
            v = N'($urandom);
            io_i = v;
            tick();
            check("sync.lat1", 32'(alt_in_o), 32'(prev));
            tick();
            check("sync.lat2", 32'(alt_in_o), 32'(v));
            rd(A_GPIO, 0, d);
            check("gpio.read", 32'(d), 32'(v));
            prev = v;
        end

        // nRST pulse of 5, then a restart three cycles in.
        set_plen(5);
        pwr_write(8'h03);
        chk_ctrl("pulse");
        for (int k = 0; k < 7; k++) begin tick(); chk_ctrl("pulse"); end
        pwr_write(8'h03);
        tick(); chk_ctrl("restart");
        tick(); chk_ctrl("restart");
        pwr_write(8'h03);
        chk_ctrl("restart");
        for (int k = 0; k < 7; k++) begin tick(); chk_ctrl("restart"); end

        // Random pulse requests with varying lengths, including zero.
        for (int blk = 0; blk < 4; blk++) begin
            set_plen($urandom_range(0, 6));
            for (int k = 0; k < 25; k++) begin
                if ($urandom_range(0, 5) == 0) pwr_write(8'h03);
                else tick();
                chk_ctrl("rpulse");
            end
        end

        // Requests while off or settling are dropped; bit2 clears the flag.
        pwr_write(8'h00);
        chk_ctrl("off");
        set_settle(30);
        pwr_write(8'h01);
        tick();
        pwr_write(8'h03);
        chk_ctrl("drop.settle");
        check("drop.flag", 32'(status_o[1]), 32'd1);
        pwr_write(8'h05);
        chk_ctrl("drop.clear");
        pwr_write(8'h02);
        chk_ctrl("drop.offreq");
        check("drop.offreq_flag", 32'(status_o[1]), 32'd1);
        pwr_write(8'h04);
        chk_ctrl("drop.clear2");

        // Power-off during an active pulse.
        set_settle(0);
        pwr_write(8'h01);
        chk_ctrl("s0");
        tick(); chk_ctrl("s0"); chk_io("s0");
        set_plen(20);
        pwr_write(8'h03);
        tick(); tick();
        chk_ctrl("longpulse");
        pwr_write(8'h00);
        chk_ctrl("abort");
        chk_io("abort");

        // Asynchronous reset in the middle of a pulse.
        pwr_write(8'h01);
        tick(); tick();
        pwr_write(8'h03);
        tick();
        chk_ctrl("prereset");
        #2 reset_i = 1'b1;
        #1;
        model_reset();
        check("areset.io_oe", 32'(io_oe), 32'h0);
        check("areset.nrst_oe", 32'(nrst_oe), 32'd0);
        check("areset.npower", 32'(target_npower), 32'd1);
        check("areset.status", 32'(status_o), 32'd0);
        tick();
        reset_i = 1'b0;
        tick();
        rd(A_PWR, 3, d);
        check("areset.plen", 32'(d), 32'h0);
        chk_ctrl("after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
